// File: rtl/donut_scanout.sv
// rtl/donut_scanout.sv - VGA 640x480 scanout of the 160x120 donut framebuffer, 4x upscaled
// Optional DONUT_SCANOUT_BORDER_EN: forces a 4'hF border on the visible frame edge.
module donut_scanout #(
    parameter int H_ACTIVE    = 640,
    parameter int H_FP        = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int V_ACTIVE    = 480,
    parameter int V_FP        = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33,
    parameter int SCALE_SHIFT = 2,
    parameter int FB_WIDTH    = 160,
    parameter int ADDR_W      = 15
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cen_i,
    output logic [ADDR_W-1:0] fb_addr_o,
    input  logic [3:0]        fb_data_i,
    output logic              hsync_o,
    output logic              vsync_o,
    output logic              de_o,
    output logic [3:0]        pix_o,
    output logic              frame_start_o,
    output logic              vblank_o
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int H_W     = $clog2(H_TOTAL);
    localparam int V_W     = $clog2(V_TOTAL);

    localparam logic [H_W-1:0]    H_LAST   = H_W'(H_TOTAL - 1);
    localparam logic [H_W-1:0]    H_VIS    = H_W'(H_ACTIVE);
    localparam logic [H_W-1:0]    HS_START = H_W'(H_ACTIVE + H_FP);
    localparam logic [H_W-1:0]    HS_END   = H_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [V_W-1:0]    V_LAST   = V_W'(V_TOTAL - 1);
    localparam logic [V_W-1:0]    V_VIS    = V_W'(V_ACTIVE);
    localparam logic [V_W-1:0]    VS_START = V_W'(V_ACTIVE + V_FP);
    localparam logic [V_W-1:0]    VS_END   = V_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [ADDR_W-1:0] FB_STEP  = ADDR_W'(FB_WIDTH);

    logic [H_W-1:0]    h_cnt;
    logic [V_W-1:0]    v_cnt;
    logic [ADDR_W-1:0] row_base;

    logic h_wrap, v_wrap, v_group_end;
    logic hs_pulse0, vs_pulse0, de0, vb0, fs0;
    logic hs_pulse1, vs_pulse1, de1, vb1, fs1;

    always_comb begin
        h_wrap      = (h_cnt == H_LAST);
        v_wrap      = (v_cnt == V_LAST);
        v_group_end = &v_cnt[SCALE_SHIFT-1:0];
        hs_pulse0   = (h_cnt >= HS_START) && (h_cnt < HS_END);
        vs_pulse0   = (v_cnt >= VS_START) && (v_cnt < VS_END);
        de0         = (h_cnt < H_VIS) && (v_cnt < V_VIS);
        vb0         = (v_cnt >= V_VIS);
        fs0         = (h_cnt == '0) && (v_cnt == '0);
    end

    // Row base steps one framebuffer row after every SCALE lines, avoiding a multiplier.
    assign fb_addr_o = de0 ? (row_base + ADDR_W'(h_cnt >> SCALE_SHIFT)) : '0;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            h_cnt    <= '0;
            v_cnt    <= '0;
            row_base <= '0;
        end else if (cen_i) begin
            if (h_wrap) begin
                h_cnt <= '0;
                if (v_wrap) begin
                    v_cnt    <= '0;
                    row_base <= '0;
                end else begin
                    v_cnt <= v_cnt + 1'b1;
                    if ((v_cnt < V_VIS) && v_group_end)
                        row_base <= row_base + FB_STEP;
                end
            end else begin
                h_cnt <= h_cnt + 1'b1;
            end
        end
    end

`ifdef DONUT_SCANOUT_BORDER_EN
    localparam logic [H_W-1:0] H_EDGE = H_W'(H_ACTIVE - 1);
    localparam logic [V_W-1:0] V_EDGE = V_W'(V_ACTIVE - 1);
    logic bd0, bd1;

    assign bd0 = de0 && ((h_cnt == '0) || (h_cnt == H_EDGE) ||
                         (v_cnt == '0) || (v_cnt == V_EDGE));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            bd1 <= 1'b0;
        else if (cen_i)
            bd1 <= bd0;
    end
`endif

    // Stage 1 lines up with the RAM capturing fb_addr_o; sync kept as active-high pulses.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hs_pulse1 <= 1'b0;
            vs_pulse1 <= 1'b0;
            de1       <= 1'b0;
            vb1       <= 1'b0;
            fs1       <= 1'b0;
        end else if (cen_i) begin
            hs_pulse1 <= hs_pulse0;
            vs_pulse1 <= vs_pulse0;
            de1       <= de0;
            vb1       <= vb0;
            fs1       <= fs0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hsync_o       <= 1'b1;
            vsync_o       <= 1'b1;
            de_o          <= 1'b0;
            pix_o         <= 4'h0;
            frame_start_o <= 1'b0;
            vblank_o      <= 1'b0;
        end else if (cen_i) begin
            hsync_o       <= ~hs_pulse1;
            vsync_o       <= ~vs_pulse1;
            de_o          <= de1;
            frame_start_o <= fs1;
            vblank_o      <= vb1;
`ifdef DONUT_SCANOUT_BORDER_EN
            pix_o         <= de1 ? (bd1 ? 4'hF : fb_data_i) : 4'h0;
`else
            pix_o         <= de1 ? fb_data_i : 4'h0;
`endif
        end
    end

endmodule

// File: tb/tb_donut_scanout.sv
// tb/tb_donut_scanout.sv - self-checking bench for donut_scanout (full-size and shrunken-timing instances)
module tb_donut_scanout;

    typedef struct packed {
        logic       hs;
        logic       vs;
        logic       de;
        logic [3:0] pix;
        logic       fs;
        logic       vb;
    } out_t;

    typedef struct {
        logic [3:0] pat;
        int         clocks;
        int         hs_low;
        int         de_cnt;
    } phase_t;

    localparam out_t IDLE = '{hs: 1'b1, vs: 1'b1, de: 1'b0, pix: 4'h0, fs: 1'b0, vb: 1'b0};

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic cen = 1'b0;

    logic [14:0] fb_addr;
    logic [3:0]  ram_q = 4'h0;
    logic        hsync, vsync, de, frame_start, vblank;
    logic [3:0]  pix;

    logic        rst_s = 1'b1;
    logic [5:0]  s_addr;
    logic [3:0]  s_ram_q = 4'h0;
    logic        s_hsync, s_vsync, s_de, s_fs, s_vb;
    logic [3:0]  s_pix;

    int n_checks = 0;
    int n_fail   = 0;
    int mh = 0, mv = 0;
    int cnt_hs_low, cnt_de;
    bit small_done = 0;
    out_t sb[$];
    out_t last_exp;

    always #5 clk = ~clk;

    donut_scanout dut (
        .clk_i(clk), .rst_i(rst), .cen_i(cen), .fb_addr_o(fb_addr), .fb_data_i(ram_q),
        .hsync_o(hsync), .vsync_o(vsync), .de_o(de), .pix_o(pix),
        .frame_start_o(frame_start), .vblank_o(vblank)
    );

    donut_scanout #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(2),
        .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .SCALE_SHIFT(2), .FB_WIDTH(4), .ADDR_W(6)
    ) dut_s (
        .clk_i(clk), .rst_i(rst_s), .cen_i(1'b1), .fb_addr_o(s_addr), .fb_data_i(s_ram_q),
        .hsync_o(s_hsync), .vsync_o(s_vsync), .de_o(s_de), .pix_o(s_pix),
        .frame_start_o(s_fs), .vblank_o(s_vb)
    );

    // One-cycle-latency RAM whose contents are the low address nibble.
    always @(posedge clk) if (cen) ram_q <= fb_addr[3:0];
    always @(posedge clk) s_ram_q <= s_addr[3:0];

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (h=%0d v=%0d t=%0t)", name, act, exp, mh, mv, $time);
        end
    endfunction

    function automatic int addr_of(int h, int v);
        return (h < 640 && v < 480) ? (v / 4) * 160 + h / 4 : 0;
    endfunction

    function automatic out_t model_out(int h, int v);
        out_t o;
        int a;
        a = addr_of(h, v);
        o.hs  = !(h >= 656 && h < 752);
        o.vs  = !(v >= 490 && v < 492);
        o.de  = (h < 640 && v < 480);
        o.pix = o.de ? a[3:0] : 4'h0;
`ifdef DONUT_SCANOUT_BORDER_EN
        if (o.de && (h == 0 || h == 639 || v == 0 || v == 479)) o.pix = 4'hF;
`endif
        o.fs  = (h == 0 && v == 0);
        o.vb  = (v >= 480);
        return o;
    endfunction

    task automatic model_reset();
        mh = 0;
        mv = 0;
        sb.delete();
        sb.push_back(IDLE);
        last_exp = IDLE;
    endtask

    task automatic step(input logic c);
        out_t e;
        cen = c;
        check("fb_addr", 32'(fb_addr), 32'(addr_of(mh, mv)));
        @(posedge clk);
        #1;
        if (c) begin
            sb.push_back(model_out(mh, mv));
            if (mh == 799) begin
                mh = 0;
                mv = (mv == 524) ? 0 : mv + 1;
            end else begin
                mh++;
            end
            e = sb.pop_front();
            last_exp = e;
            if (!hsync) cnt_hs_low++;
            if (de) cnt_de++;
        end else begin
            e = last_exp;
        end
        check("scan_out", 32'({hsync, vsync, de, pix, frame_start, vblank}), 32'(e));
    endtask

    task automatic check_reset_outputs(string tag);
        check({tag, "_fb_addr"}, 32'(fb_addr), 0);
        check({tag, "_hsync"}, 32'(hsync), 1);
        check({tag, "_vsync"}, 32'(vsync), 1);
        check({tag, "_de"}, 32'(de), 0);
        check({tag, "_pix"}, 32'(pix), 0);
        check({tag, "_frame_start"}, 32'(frame_start), 0);
        check({tag, "_vblank"}, 32'(vblank), 0);
    endtask

    // Shrunken-timing instance: 24x12 total, 288 cycles per frame, frame-level properties.
    initial begin : small_test
        bit found;
        int sum_addr, max_addr, n_vs, n_hs, n_de, n_vb, n_fs;
        repeat (3) @(posedge clk);
        #1 rst_s = 1'b0;
        found = 0;
        for (int i = 0; i < 400 && !found; i++) begin
            @(posedge clk);
            #1;
            if (s_fs) found = 1;
        end
        check("small_fs_found", 32'(found), 1);
        for (int f = 0; f < 2; f++) begin
            sum_addr = 0; max_addr = 0; n_vs = 0; n_hs = 0; n_de = 0; n_vb = 0; n_fs = 0;
            for (int k = 0; k < 288; k++) begin
                sum_addr += int'(s_addr);
                if (int'(s_addr) > max_addr) max_addr = int'(s_addr);
                if (!s_vsync) n_vs++;
                if (!s_hsync) n_hs++;
                if (s_de) n_de++;
                if (s_vb) n_vb++;
                if (s_fs) n_fs++;
                @(posedge clk);
                #1;
            end
            check("small_fs_period", 32'(s_fs), 1);
            check("small_fs_count", 32'(n_fs), 1);
            check("small_addr_sum", 32'(sum_addr), 448);
            check("small_addr_max", 32'(max_addr), 7);
            check("small_vsync_low", 32'(n_vs), 48);
            check("small_hsync_low", 32'(n_hs), 48);
            check("small_de_count", 32'(n_de), 128);
            check("small_vblank_count", 32'(n_vb), 96);
        end
        small_done = 1;
    end

    initial begin : main_test
        phase_t phases[4];
        phases[0] = '{pat: 4'b1111, clocks: 1600, hs_low: 192, de_cnt: 1280};
        phases[1] = '{pat: 4'b1001, clocks: 3200, hs_low: 192, de_cnt: 1280};
        phases[2] = '{pat: 4'b0101, clocks: 1600, hs_low: 96,  de_cnt: 640};
        phases[3] = '{pat: 4'b0001, clocks: 3200, hs_low: 96,  de_cnt: 640};

        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;
        model_reset();

        for (int p = 0; p < 4; p++) begin
            cnt_hs_low = 0;
            cnt_de = 0;
            for (int i = 0; i < phases[p].clocks; i++) step(phases[p].pat[i % 4]);
            check($sformatf("phase%0d_hsync_low", p), 32'(cnt_hs_low), 32'(phases[p].hs_low));
            check($sformatf("phase%0d_de_count", p), 32'(cnt_de), 32'(phases[p].de_cnt));
        end

        // Async reset in the middle of an active line.
        for (int i = 0; i < 300; i++) step(1'b1);
        check("pre_reset_h", 32'(mh), 300);
        #2 rst = 1'b1;
        #1;
        check_reset_outputs("midframe");
        repeat (2) begin
            cen = 1'b1;
            @(posedge clk);
        end
        #1;
        check_reset_outputs("held");
        rst = 1'b0;
        model_reset();
        step(1'b1);
        check("fs_after_1", 32'(frame_start), 0);
        step(1'b1);
        check("fs_after_2", 32'(frame_start), 1);
        check("de_with_fs", 32'(de), 1);
        for (int i = 0; i < 1000; i++) step(1'b1);

        for (int i = 0; i < 5000 && !small_done; i++) @(posedge clk);
        check("small_test_done", 32'(small_done), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/donut_scanout.md
Name: donut_scanout

Overview:
- Read-side consumer of the 32K x 4-bit donut framebuffer.
- Generates 640x480@60 VGA timing and issues framebuffer read addresses.
- Upscales a 160x120 luminance image by 4x in each direction.
- Realigns the 1-cycle RAM read data with sync/blanking and drives the 4-bit pixel index to the display/palette stage.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, hsync width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch
- V_SYNC, 2, vsync width
- V_BP, 33, vertical back porch
- SCALE_SHIFT, 2, log2 of the upscale factor (4x)
- FB_WIDTH, 160, framebuffer row pitch in pixels
- ADDR_W, 15, framebuffer address width

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  asynchronous, active-high reset
- cen_i  in  1  pixel enable; all state advances only on edges with cen_i=1; same enable drives the RAM
- fb_addr_o  out  ADDR_W  framebuffer read address
- fb_data_i  in  4  RAM read data; valid one enabled edge after fb_addr_o
- hsync_o  out  1  horizontal sync, active low
- vsync_o  out  1  vertical sync, active low
- de_o  out  1  data enable (visible region)
- pix_o  out  4  pixel luminance index; 0 when de_o=0
- frame_start_o  out  1  one-enabled-cycle pulse coincident with output pixel (0,0)
- vblank_o  out  1  high while output line is outside the active region

Behaviour:
- Reset (async, rst_i=1):
  - h_cnt=0, v_cnt=0, row_base=0, all pipeline registers 0.
  - Outputs: fb_addr_o=0, hsync_o=1, vsync_o=1, de_o=0, pix_o=0, frame_start_o=0, vblank_o=0.
- Counters:
  - h_cnt runs 0..799 (sum of H params minus 1) and wraps to 0.
  - v_cnt increments when h_cnt wraps; runs 0..524 and wraps to 0.
  - Both hold when cen_i=0.
- Address generation (stage 0), no multiplier:
  - row_base is a register. At v_cnt wrap it is cleared to 0.
  - When h_cnt wraps and v_cnt is the last line of a 4-line group inside the active region, row_base += FB_WIDTH.
  - fb_addr_o = row_base + (h_cnt >> SCALE_SHIFT) while h_cnt<H_ACTIVE and v_cnt<V_ACTIVE; otherwise 0.
  - fb_addr_o is combinational from registered state, so the RAM captures it at the next enabled edge.
  - Max address 119*160+159=19199; never exceeds 2^ADDR_W-1.
- Timing decode from counters:
  - hs0 = !(656<=h_cnt<752).
  - vs0 = !(490<=v_cnt<492).
  - de0 = h_cnt<640 && v_cnt<480.
  - vb0 = v_cnt>=480.
  - fs0 = (h_cnt==0 && v_cnt==0).
- Pipeline:
  - Stage 1: hs0/vs0/de0/vb0/fs0 registered on the same enabled edge where the RAM latches data.
  - Stage 2: outputs registered from stage 1; pix_o <= de1 ? fb_data_i : 0.
  - Total latency from counter state to outputs: exactly 2 enabled edges. All outputs mutually aligned.
- cen_i=0: every register holds; outputs frozen.
- Reset mid-frame: immediate return to reset values. The first frame_start_o pulse follows 2 enabled edges after rst_i deasserts.

Optional Feature:
- Macro: DONUT_SCANOUT_BORDER_EN.
- Defined: when de0=1 and (h_cnt==0 || h_cnt==639 || v_cnt==0 || v_cnt==479), the stage-2 pix_o is forced to 4'hF regardless of fb_data_i. Used for monitor alignment. fb_addr_o is unchanged.
- Undefined: no override; pix_o always follows fb_data_i in the active region.

Test Plan:
- Reset, then cen_i=1 continuously -> hsync_o low for exactly 96 enabled cycles per 800-cycle line; vsync_o low for exactly 2 lines (1600 cycles) per 525-line frame.
- RAM model with 1-cycle latency, data = addr[3:0] -> on output line 0, pix_o shows 0,0,0,0,1,1,1,1,...; output lines 0-3 identical; line 4 starts at value 0 (addr 160).
- Track fb_addr_o over one frame -> maximum 19199, value 0 at every non-active position, row_base back to 0 after v_cnt wrap.
- Toggle cen_i as 1,0,0,1 pattern -> output sequence identical to continuous cen_i, only stretched in time; no skipped or duplicated pixels.
- Assert rst_i at h_cnt=300, v_cnt=200 -> all outputs at reset values immediately; frame_start_o pulses 2 enabled edges after release, with de_o=1 in the same cycle.
- With DONUT_SCANOUT_BORDER_EN and fb_data_i=4'h3 -> pix_o=4'hF at output (0,y), (639,y), (x,0), (x,479); 4'h3 elsewhere in the active region.
